// File: rtl/paraschiv_pkg.sv
// Shared definitions for the byte-wise additive cipher: FSM states,
// per-byte encrypt/decrypt helpers and the default key.
package paraschiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dec_state_t;

    localparam logic [31:0] DEFAULT_KEY = 32'h04030201;

    function automatic logic [7:0] enc_byte(input logic [7:0] p, input logic [7:0] k);
        return p + k;
    endfunction

    function automatic logic [7:0] dec_byte(input logic [7:0] c, input logic [7:0] k);
        return c - k;
    endfunction

endpackage

// File: rtl/key_rotator.sv
// Latched key register with a cyclic byte index; presents the key byte
// selected by the index for the current ciphertext beat.
module key_rotator #(
    parameter int KEY_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [8*KEY_LEN-1:0] key_i,
    input  logic                 advance_i,
    output logic [7:0]           key_byte_o
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    logic [8*KEY_LEN-1:0] key_q, key_d;
    logic [KW-1:0]        idx_q, idx_d;

    // Next-state: load restarts at key byte 0, advance wraps at KEY_LEN-1
    always_comb begin
        key_d = key_q;
        idx_d = idx_q;
        if (load_i) begin
            key_d = key_i;
            idx_d = '0;
        end else if (advance_i) begin
            if (idx_q == KW'(KEY_LEN - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + KW'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Key and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            idx_q <= '0;
        end else begin
            key_q <= key_d;
            idx_q <= idx_d;
        end
    end

    // Current key byte: byte j sits at bit offset 8*j
    always_comb begin
        key_byte_o = 8'(key_q >> {idx_q, 3'b000});
    end

endmodule

// File: rtl/stream_decrypt.sv
// Byte-serial decryptor: one ciphertext byte in per handshake, plaintext
// byte out one cycle later through a single output register.
module stream_decrypt
    import paraschiv_pkg::*;
#(
    parameter int MSG_LEN = 9,
    parameter int KEY_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] key_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    dec_state_t  state_q, state_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        done_q, done_d;
    logic        in_ready_s;
    logic        key_load_s;
    logic        key_adv_s;
    logic [7:0]  key_byte_s;

    key_rotator #(
        .KEY_LEN (KEY_LEN)
    ) u_key_rotator (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (key_load_s),
        .key_i      (key_in),
        .advance_i  (key_adv_s),
        .key_byte_o (key_byte_s)
    );

    // Next-state and handshake logic for IDLE -> RUN -> DRAIN -> IDLE
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        in_ready_s  = 1'b0;
        key_load_s  = 1'b0;
        key_adv_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_load_s = 1'b1;
                    byte_idx_d = '0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                in_ready_s = !out_valid_q || out_ready;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
                // A new byte may be loaded in the same cycle the old one leaves
                if (in_valid && in_ready_s) begin
                    out_data_d  = dec_byte(in_data, key_byte_s);
                    out_valid_d = 1'b1;
                    out_last_d  = (byte_idx_q == BW'(MSG_LEN - 1));
                    key_adv_s   = 1'b1;
                    if (byte_idx_q == BW'(MSG_LEN - 1)) begin
                        byte_idx_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_stream_decrypt.sv
// Scoreboard bench for stream_decrypt: expected {last, byte} pushed on each
// accepted input beat and popped when the output handshake occurs.
module tb_stream_decrypt;
    import paraschiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key_in = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    stream_decrypt #(.MSG_LEN(9), .KEY_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Output monitor: pop and compare on every output handshake, count done pulses
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_underflow: got last=%0b data=%h, expected nothing", out_last, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    n_fails++;
                    $display("FAIL out_beat: got last=%0b data=%h, expected last=%0b data=%h",
                             out_last, out_data, e[8], e[7:0]);
                end
            end
        end
        if (rst_n && done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] pch(input int i);
        logic [71:0] s;
        s = "PARASCHIV";
        return s[71-8*i -: 8];
    endfunction

    function automatic logic [7:0] kbyte(input logic [31:0] k, input int i);
        logic [31:0] sh;
        sh = k >> (8 * (i % 4));
        return sh[7:0];
    endfunction

    task automatic start_msg(input logic [31:0] k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] c, input logic [8:0] e);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = c;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: byte %h not accepted, in_ready=%0b", c, in_ready);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_paraschiv(input logic [31:0] k);
        for (int i = 0; i < 9; i++)
            send_byte(enc_byte(pch(i), kbyte(k, i)), {(i == 8), pch(i)});
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_data, out_last, in_ready, busy, done} !== 13'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: got v=%0b d=%h l=%0b ir=%0b b=%0b dn=%0b, expected all 0",
                     out_valid, out_data, out_last, in_ready, busy, done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal;
        logic [7:0] ct [9];
        int d0;
        bit ok;
        ct = '{8'd81, 8'd67, 8'd85, 8'd69, 8'd84, 8'd69, 8'd75, 8'd77, 8'd87};
        d0 = done_cnt;
        start_msg(DEFAULT_KEY);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL nominal_busy: got %0b, expected 1", busy);
        end
        send_byte(ct[0], {1'b0, 8'h50});
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h50) begin
            n_fails++;
            $display("FAIL nominal_latency: got v=%0b d=%h, expected v=1 d=50", out_valid, out_data);
        end
        for (int i = 1; i < 9; i++) send_byte(ct[i], {(i == 8), pch(i)});
        wait_idle(ok);
        n_checks++;
        if (!ok || busy !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL nominal_end: got busy=%0b dones=%0d left=%0d, expected busy=0 dones=1 left=0",
                     busy, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        bit ok;
        start_msg(32'h3355FF01);
        send_byte(8'h00, {1'b0, 8'hFF});
        send_byte(8'h05, {1'b0, 8'h06});
        for (int i = 2; i < 9; i++) send_byte(8'(i * 37), {(i == 8), 8'(i * 37) - kbyte(32'h3355FF01, i)});
        wait_idle(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL wrap_end: got idle=%0b left=%0d, expected idle=1 left=0", ok, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        start_msg(DEFAULT_KEY);
        for (int i = 0; i < 5; i++) send_byte(enc_byte(pch(i), kbyte(DEFAULT_KEY, i)), {1'b0, pch(i)});
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = enc_byte(pch(5), kbyte(DEFAULT_KEY, 5));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h53 || out_last !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_hold: got ir=%0b v=%0b d=%h l=%0b, expected ir=0 v=1 d=53 l=0",
                         in_ready, out_valid, out_data, out_last);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 5; i < 9; i++) send_byte(enc_byte(pch(i), kbyte(DEFAULT_KEY, i)), {(i == 8), pch(i)});
        wait_idle(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL stall_end: got idle=%0b left=%0d, expected idle=1 left=0", ok, exp_q.size());
        end
    endtask

    task automatic test_key_rotation;
        bit ok;
        logic [7:0] pt [4];
        pt = '{8'h70, 8'h60, 8'h50, 8'h40};
        for (int m = 0; m < 2; m++) begin
            start_msg(32'h40302010);
            for (int i = 0; i < 9; i++) send_byte(8'h80, {(i == 8), pt[i % 4]});
            wait_idle(ok);
            n_checks++;
            if (!ok || exp_q.size() != 0) begin
                n_fails++;
                $display("FAIL rotation_end msg%0d: got idle=%0b left=%0d, expected idle=1 left=0",
                         m, ok, exp_q.size());
            end
        end
    endtask

    task automatic test_reset_midop;
        bit ok;
        start_msg(DEFAULT_KEY);
        for (int i = 0; i < 5; i++) send_byte(enc_byte(pch(i), kbyte(DEFAULT_KEY, i)), {1'b0, pch(i)});
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_last, in_ready, busy, done} !== 13'h0) begin
            n_fails++;
            $display("FAIL midop_reset: got v=%0b d=%h l=%0b ir=%0b b=%0b dn=%0b, expected all 0",
                     out_valid, out_data, out_last, in_ready, busy, done);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_msg(32'hA5C3E1F7);
        send_paraschiv(32'hA5C3E1F7);
        wait_idle(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL midop_fresh: got idle=%0b left=%0d, expected idle=1 left=0", ok, exp_q.size());
        end
    endtask

    task automatic test_protocol;
        bit ok;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_no_accept: got ir=%0b v=%0b, expected 0 0", in_ready, out_valid);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start_msg(32'h11223344);
        for (int i = 0; i < 3; i++) send_byte(enc_byte(pch(i), kbyte(32'h11223344, i)), {1'b0, pch(i)});
        key_in = 32'hDEADBEEF;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int i = 3; i < 9; i++) send_byte(enc_byte(pch(i), kbyte(32'h11223344, i)), {(i == 8), pch(i)});
        wait_idle(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL protocol_end: got idle=%0b left=%0d busy=%0b, expected 1 0 0",
                     ok, exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_backpressure();
        test_key_rotation();
        test_reset_midop();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
